// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline types for the hazard sequencer: FSM state encoding,
// per-buffer-register control strobes and the load-use compare helper.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned HZ_STATE_W = 2;

  typedef enum logic [HZ_STATE_W-1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } hz_state_e;

  // Load enable and synchronous clear for one pipeline buffer register.
  typedef struct packed {
    logic en;
    logic clr;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_RUN    = '{en: 1'b1, clr: 1'b0};
  localparam pipe_ctl_t CTL_HOLD   = '{en: 1'b0, clr: 1'b0};
  localparam pipe_ctl_t CTL_BUBBLE = '{en: 1'b0, clr: 1'b1};

  // Load in EX whose destination feeds the instruction in ID; x0 never hazards.
  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] rd,
                                        input logic [4:0] rs1,
                                        input logic [4:0] rs2);
    return memread && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Saturating count of consecutive data-memory wait cycles. `expired` flags the
// wait cycle on which the count reaches MEM_TIMEOUT_CYC.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT_CYC = 64,
  parameter int unsigned TMR_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT_CYC);

  logic [TMR_W-1:0] cnt;

  // Count wait cycles, holding at LIMIT so the value never wraps.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign expired = inc && (cnt >= (LIMIT - TMR_W'(1)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Optional build macro PIPE_HAZARD_PERF_EN adds stall/flush/memwait
// performance counters as extra outputs.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT_CYC = 64,
  parameter int unsigned TMR_W           = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_memread,
  input  logic                  ex_redirect,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_clr,
  output logic                  idex_clr,
  output logic                  exmem_clr,
  output logic                  memwb_clr,
  output logic                  mem_err,
  output logic [HZ_STATE_W-1:0] state_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_memwait_cnt
`endif
);

  hz_state_e state, state_nxt;
  pipe_ctl_t ifid_c, idex_c, exmem_c, memwb_c;
  logic      pc_load;
  logic      lu_haz, mw_haz, mem_stall, expired, mem_err_q;
  logic      apply_stall, apply_flush, apply_memwait;

  assign lu_haz = load_use_hit(ex_memread, ex_rd, id_rs1, id_rs2);
  assign mw_haz = mem_access && !dmem_ready;
  // Once waiting, only dmem_ready ends the wait; ERR ignores memory entirely.
  assign mem_stall = (state != ERR) && (mw_haz || ((state == MEM_WAIT) && !dmem_ready));

  mem_wait_timer #(
    .MEM_TIMEOUT_CYC(MEM_TIMEOUT_CYC),
    .TMR_W          (TMR_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .inc    (mem_stall),
    .clr    (!mem_stall),
    .expired(expired)
  );

  // Prioritised strobe selection: reset > memory wait > redirect > load-use.
  always_comb begin
    pc_load       = 1'b1;
    ifid_c        = CTL_RUN;
    idex_c        = CTL_RUN;
    exmem_c       = CTL_RUN;
    memwb_c       = CTL_RUN;
    state_nxt     = RUN;
    apply_stall   = 1'b0;
    apply_flush   = 1'b0;
    apply_memwait = 1'b0;
    if (reset) begin
      pc_load = 1'b0;
      ifid_c  = CTL_BUBBLE;
      idex_c  = CTL_BUBBLE;
      exmem_c = CTL_BUBBLE;
      memwb_c = CTL_BUBBLE;
    end else if (state == ERR) begin
      pc_load   = 1'b0;
      ifid_c    = CTL_HOLD;
      idex_c    = CTL_HOLD;
      exmem_c   = CTL_HOLD;
      memwb_c   = CTL_HOLD;
      state_nxt = ERR;
    end else if (mem_stall) begin
      pc_load       = 1'b0;
      ifid_c        = CTL_HOLD;
      idex_c        = CTL_HOLD;
      exmem_c       = CTL_HOLD;
      memwb_c       = CTL_BUBBLE;
      state_nxt     = expired ? ERR : MEM_WAIT;
      apply_memwait = 1'b1;
    end else if (ex_redirect) begin
      ifid_c      = CTL_BUBBLE;
      idex_c      = CTL_BUBBLE;
      apply_flush = 1'b1;
    end else if (lu_haz) begin
      pc_load     = 1'b0;
      ifid_c      = CTL_HOLD;
      idex_c      = CTL_BUBBLE;
      state_nxt   = LU_STALL;
      apply_stall = 1'b1;
    end
  end

  // FSM state and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == ERR) begin
        mem_err_q <= 1'b1;
      end
    end
  end

  assign pc_en     = pc_load;
  assign ifid_en   = ifid_c.en;
  assign idex_en   = idex_c.en;
  assign exmem_en  = exmem_c.en;
  assign memwb_en  = memwb_c.en;
  assign ifid_clr  = ifid_c.clr;
  assign idex_clr  = idex_c.clr;
  assign exmem_clr = exmem_c.clr;
  assign memwb_clr = memwb_c.clr;
  assign mem_err   = mem_err_q;
  assign state_o   = state;

`ifdef PIPE_HAZARD_PERF_EN
  // Event counters, one increment per cycle the corresponding action is applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt   <= '0;
      perf_flush_cnt   <= '0;
      perf_memwait_cnt <= '0;
    end else begin
      if (apply_stall)   perf_stall_cnt   <= perf_stall_cnt + 32'd1;
      if (apply_flush)   perf_flush_cnt   <= perf_flush_cnt + 32'd1;
      if (apply_memwait) perf_memwait_cnt <= perf_memwait_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = apply_stall ^ apply_flush ^ apply_memwait;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a stimulus process drives one input
// set per cycle and pushes the reference model's expected response; a monitor
// pops and compares on every falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        ex_memread = 1'b0, ex_redirect = 1'b0, mem_access = 1'b0, dmem_ready = 1'b1;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_clr, idex_clr, exmem_clr, memwb_clr, mem_err;
  logic [1:0]  state_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT_CYC(TO),
    .TMR_W          (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .ex_redirect(ex_redirect),
    .mem_access (mem_access),
    .dmem_ready (dmem_ready),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_en    (idex_en),
    .exmem_en   (exmem_en),
    .memwb_en   (memwb_en),
    .ifid_clr   (ifid_clr),
    .idex_clr   (idex_clr),
    .exmem_clr  (exmem_clr),
    .memwb_clr  (memwb_clr),
    .mem_err    (mem_err),
    .state_o    (state_o)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_memwait_cnt(perf_memwait_cnt)
`endif
  );

  // Expected view of one cycle: strobes are
  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_clr, exmem_clr, memwb_clr}.
  typedef struct {
    logic [8:0]  strobes;
    logic [1:0]  st;
    logic        err;
    logic [31:0] ps, pf, pm;
  } exp_t;

  exp_t sbq[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: what the pipeline is doing, not how the RTL encodes it.
  bit          m_errored = 0;
  bit          m_waiting = 0;
  bit          m_lu      = 0;
  int unsigned m_wait    = 0;
  int unsigned m_ps = 0, m_pf = 0, m_pm = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus its expected response.
  task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input bit mr, input bit rdr,
                      input bit ma, input bit rdy);
    exp_t e;
    bit   lu, mw;
    @(posedge clk);
    #1;
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_memread = mr; ex_redirect = rdr; mem_access = ma; dmem_ready = rdy;
    e.st  = m_errored ? 2'd3 : m_waiting ? 2'd2 : m_lu ? 2'd1 : 2'd0;
    e.err = m_errored;
    e.ps  = m_ps; e.pf = m_pf; e.pm = m_pm;
    lu = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    mw = ma && !rdy;
    if (rst) begin
      e.strobes = 9'b00000_1111;
      m_errored = 0; m_waiting = 0; m_lu = 0; m_wait = 0;
      m_ps = 0; m_pf = 0; m_pm = 0;
    end else if (m_errored) begin
      e.strobes = 9'b00000_0000;
    end else if (mw) begin
      e.strobes = 9'b00000_0001;
      m_wait++; m_waiting = 1; m_lu = 0; m_pm++;
      if (m_wait >= TO) m_errored = 1;
    end else if (rdr) begin
      e.strobes = 9'b10011_1100;
      m_wait = 0; m_waiting = 0; m_lu = 0; m_pf++;
    end else if (lu) begin
      e.strobes = 9'b00011_0100;
      m_wait = 0; m_waiting = 0; m_lu = 1; m_ps++;
    end else begin
      e.strobes = 9'b11111_0000;
      m_wait = 0; m_waiting = 0; m_lu = 0;
    end
    sbq.push_back(e);
  endtask

  // Monitor: outputs are combinational, so they are stable mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("strobes", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                              ifid_clr, idex_clr, exmem_clr, memwb_clr}), 32'(e.strobes));
        check("state_o", 32'(state_o), 32'(e.st));
        check("mem_err", 32'(mem_err), 32'(e.err));
`ifdef PIPE_HAZARD_PERF_EN
        check("perf_stall_cnt",   perf_stall_cnt,   e.ps);
        check("perf_flush_cnt",   perf_flush_cnt,   e.pf);
        check("perf_memwait_cnt", perf_memwait_cnt, e.pm);
`endif
      end
    end
  end

  initial begin
    logic [4:0] r1, r2, rd;
    bit         mr, rdr, ma, rdy, rst;
    int unsigned guard;

    repeat (2) @(posedge clk);
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    // load-use on rs1, then the bubble reaches EX
    step(0, 5, 7, 5, 1, 0, 0, 1);
    step(0, 5, 7, 0, 0, 0, 0, 1);
    step(0, 1, 2, 3, 0, 0, 0, 1);
    // load to x0 never stalls
    repeat (3) step(0, 0, 0, 0, 1, 0, 0, 1);
    // redirect coincident with load-use on rs2
    step(0, 1, 3, 3, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // five wait cycles (one below timeout), then completion
    repeat (5) step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // redirect frozen during a wait, applied on completion
    repeat (2) step(0, 4, 4, 4, 1, 1, 1, 0);
    step(0, 4, 4, 4, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // timeout into ERR, stays there, reset recovers
    repeat (TO) step(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    // reset mid-wait with a pending redirect
    repeat (2) step(0, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic with pipeline-plausible sequencing.
    r1 = 0; r2 = 0; rd = 0; mr = 0; rdr = 0;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (m_waiting && !m_errored) begin
        ma  = 1;
        rdy = ($urandom_range(0, 9) < 6);
      end else begin
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        mr  = m_lu ? 1'b0 : 1'($urandom_range(0, 1));
        rdr = ($urandom_range(0, 4) == 0);
        ma  = ($urandom_range(0, 3) == 0);
        rdy = 1'($urandom_range(0, 1));
      end
      step(rst, r1, r2, rd, mr, rdr, ma, rdy);
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
